// File: rtl/gshare_pkg.sv
// Shared configuration, constants and types for the gshare direction predictor.
// Speculative history shifting is selected in gshare_predictor by GSHARE_SPECULATIVE_HISTORY_EN.
package gshare_pkg;

    // Subset of the derived core configuration this predictor consumes.
    typedef struct packed {
        int unsigned GlobalPredictorSize;
        int unsigned VLEN;
        bit          RVC;
    } gshare_cfg_t;

    localparam gshare_cfg_t GSHARE_CFG_DEFAULT = '{
        GlobalPredictorSize: 512,
        VLEN:                64,
        RVC:                 1'b1
    };

    localparam logic [1:0] CTR_WEAK_NT = 2'b01;
    localparam logic [1:0] CTR_MAX     = 2'b11;

    typedef enum logic {
        IDLE,
        CLEAR
    } gshare_state_e;

    // The resolved-branch bundle is sized for the widest supported configuration.
    localparam int unsigned GSHARE_MAX_VLEN = 64;
    localparam int unsigned GSHARE_MAX_HIST = 16;

    typedef struct packed {
        logic                       valid;
        logic [GSHARE_MAX_VLEN-1:0] pc;
        logic [GSHARE_MAX_HIST-1:0] ghr;
        logic                       taken;
        logic                       mispredict;
    } gshare_upd_t;

endpackage

// File: rtl/gshare_sat_counter.sv
// Next-state function of a 2-bit saturating direction counter.
module gshare_sat_counter
    import gshare_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        // NOTE: default assignment first so every path drives ctr_o and no latch is inferred.
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != CTR_MAX) begin
                ctr_o = ctr_i + 2'd1;
            end
        end else if (ctr_i != 2'b00) begin
            ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare global-history direction predictor with a flush-driven table clear sweep.
// Define GSHARE_SPECULATIVE_HISTORY_EN to shift predicted directions into the GHR at lookup.
module gshare_predictor
    import gshare_pkg::*;
#(
    parameter gshare_cfg_t CVA6Cfg    = GSHARE_CFG_DEFAULT,
    parameter int unsigned NR_ENTRIES = CVA6Cfg.GlobalPredictorSize,
    parameter int unsigned HIST_LEN   = $clog2(NR_ENTRIES),
    parameter int unsigned PC_OFFSET  = CVA6Cfg.RVC ? 1 : 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_bp_i,
    input  logic                    debug_mode_i,
    input  logic                    lookup_valid_i,
    input  logic [CVA6Cfg.VLEN-1:0] lookup_pc_i,
    output logic                    pred_valid_o,
    output logic                    pred_taken_o,
    output logic [HIST_LEN-1:0]     pred_ghr_o,
    input  logic                    upd_valid_i,
    input  logic [CVA6Cfg.VLEN-1:0] upd_pc_i,
    input  logic [HIST_LEN-1:0]     upd_ghr_i,
    input  logic                    upd_taken_i,
    input  logic                    upd_mispredict_i,
    output logic                    busy_o
);

    localparam logic [HIST_LEN-1:0] SWEEP_LAST = HIST_LEN'(NR_ENTRIES - 1);

    logic [1:0]          ctr_q [NR_ENTRIES];
    logic [HIST_LEN-1:0] ghr_q, ghr_d;
    gshare_state_e       state_q;
    logic [HIST_LEN-1:0] sweep_q;

    gshare_upd_t         upd;
    logic [HIST_LEN-1:0] upd_ghr;
    logic [HIST_LEN-1:0] lookup_idx;
    logic [HIST_LEN-1:0] upd_idx;
    logic [1:0]          upd_ctr_next;
    logic                train_en;
    logic                wr_en;
    logic [HIST_LEN-1:0] wr_idx;
    logic [1:0]          wr_data;
    logic                unused_bits;

    assign upd = '{
        valid:      upd_valid_i,
        pc:         GSHARE_MAX_VLEN'(upd_pc_i),
        ghr:        GSHARE_MAX_HIST'(upd_ghr_i),
        taken:      upd_taken_i,
        mispredict: upd_mispredict_i
    };
    assign upd_ghr = upd.ghr[HIST_LEN-1:0];

    // Only the index slice of each PC participates; the rest is folded away here.
    assign unused_bits = ^{lookup_pc_i, upd};

    assign lookup_idx   = lookup_pc_i[PC_OFFSET +: HIST_LEN] ^ ghr_q;
    assign upd_idx      = upd.pc[PC_OFFSET +: HIST_LEN] ^ upd_ghr;

    assign pred_valid_o = lookup_valid_i && (state_q == IDLE);
    assign pred_taken_o = ctr_q[lookup_idx][1];
    assign pred_ghr_o   = ghr_q;
    assign busy_o       = (state_q == CLEAR);

    gshare_sat_counter u_sat_counter (
        .ctr_i   (ctr_q[upd_idx]),
        .taken_i (upd.taken),
        .ctr_o   (upd_ctr_next)
    );

    assign train_en = (state_q == IDLE) && !debug_mode_i && upd.valid;

    // Single write port: the clear sweep owns it while in CLEAR, training otherwise.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = upd_idx;
        wr_data = upd_ctr_next;
        if (state_q == CLEAR) begin
            wr_en   = 1'b1;
            wr_idx  = sweep_q;
            wr_data = CTR_WEAK_NT;
        end else if (train_en) begin
            wr_en = 1'b1;
        end
    end

    // NOTE: the table is built from flops rather than an SRAM macro because every counter must reset to weakly not-taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                ctr_q[i] <= CTR_WEAK_NT;
            end
        end else if (wr_en) begin
            ctr_q[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        ghr_d = ghr_q;
        if (state_q == IDLE) begin
            if (flush_bp_i) begin
                ghr_d = '0;
            end else if (!debug_mode_i) begin
                if (upd.valid && upd.mispredict) begin
                    ghr_d = {upd_ghr[HIST_LEN-2:0], upd.taken};
`ifdef GSHARE_SPECULATIVE_HISTORY_EN
                end else if (pred_valid_o) begin
                    ghr_d = {ghr_q[HIST_LEN-2:0], pred_taken_o};
`else
                end else if (upd.valid) begin
                    ghr_d = {ghr_q[HIST_LEN-2:0], upd.taken};
`endif
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    // A flush during CLEAR restarts the sweep from entry 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sweep_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (flush_bp_i) begin
                        state_q <= CLEAR;
                        sweep_q <= '0;
                    end
                end
                CLEAR: begin
                    if (flush_bp_i) begin
                        sweep_q <= '0;
                    end else begin
                        sweep_q <= sweep_q + 1'b1;
                        if (sweep_q == SWEEP_LAST) begin
                            state_q <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: directed scenarios plus random traffic against a table model.
module tb_gshare_predictor;
    import gshare_pkg::*;

    localparam int N = 512;
    localparam int H = 9;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_bp_i = 1'b0;
    logic          debug_mode_i = 1'b0;
    logic          lookup_valid_i = 1'b0;
    logic [63:0]   lookup_pc_i = '0;
    logic          pred_valid_o;
    logic          pred_taken_o;
    logic [H-1:0]  pred_ghr_o;
    logic          upd_valid_i = 1'b0;
    logic [63:0]   upd_pc_i = '0;
    logic [H-1:0]  upd_ghr_i = '0;
    logic          upd_taken_i = 1'b0;
    logic          upd_mispredict_i = 1'b0;
    logic          busy_o;

    gshare_predictor dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_bp_i       (flush_bp_i),
        .debug_mode_i     (debug_mode_i),
        .lookup_valid_i   (lookup_valid_i),
        .lookup_pc_i      (lookup_pc_i),
        .pred_valid_o     (pred_valid_o),
        .pred_taken_o     (pred_taken_o),
        .pred_ghr_o       (pred_ghr_o),
        .upd_valid_i      (upd_valid_i),
        .upd_pc_i         (upd_pc_i),
        .upd_ghr_i        (upd_ghr_i),
        .upd_taken_i      (upd_taken_i),
        .upd_mispredict_i (upd_mispredict_i),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // Model state: counter values, history, and cycles left in a clear sweep.
    int m_ctr [N];
    int m_ghr;
    int m_busy_left;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pc_idx(input logic [63:0] pc);
        return int'(pc[9:1]);
    endfunction

    // A lookup PC whose index lands on table entry idx under the current history.
    function automatic logic [63:0] pc_for(input int idx);
        logic [63:0] p;
        p      = {$urandom, $urandom};
        p[9:1] = 9'(idx ^ m_ghr);
        return p;
    endfunction

    function automatic logic [63:0] upd_pc_of(input int idx);
        return 64'(idx) << 1;
    endfunction

    task automatic model_reset();
        foreach (m_ctr[i]) m_ctr[i] = 1;
        m_ghr       = 0;
        m_busy_left = 0;
    endtask

    initial begin : compare_proc
        bit busy;
        bit ev;
        bit et;
        int idx;
        int u;
        model_reset();
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                model_reset();
                check("rst_busy", 64'(busy_o), 64'(0));
                check("rst_ghr", 64'(pred_ghr_o), 64'(0));
                check("rst_valid", 64'(pred_valid_o), 64'(0));
            end else begin
                busy = (m_busy_left > 0);
                ev   = lookup_valid_i && !busy;
                idx  = pc_idx(lookup_pc_i) ^ m_ghr;
                et   = (m_ctr[idx] >= 2);
                check("busy", 64'(busy_o), 64'(busy));
                check("pred_valid", 64'(pred_valid_o), 64'(ev));
                check("pred_ghr", 64'(pred_ghr_o), 64'(m_ghr));
                if (!busy) check("pred_taken", 64'(pred_taken_o), 64'(et));
                if (busy) begin
                    if (flush_bp_i) begin
                        m_busy_left = N;
                    end else begin
                        m_busy_left--;
                        if (m_busy_left == 0) foreach (m_ctr[i]) m_ctr[i] = 1;
                    end
                end else begin
                    if (upd_valid_i && !debug_mode_i) begin
                        u = pc_idx(upd_pc_i) ^ int'(upd_ghr_i);
                        if (upd_taken_i) m_ctr[u] = (m_ctr[u] == 3) ? 3 : m_ctr[u] + 1;
                        else             m_ctr[u] = (m_ctr[u] == 0) ? 0 : m_ctr[u] - 1;
                    end
                    if (flush_bp_i) begin
                        m_ghr       = 0;
                        m_busy_left = N;
                    end else if (!debug_mode_i) begin
                        if (upd_valid_i && upd_mispredict_i) begin
                            m_ghr = ((int'(upd_ghr_i) << 1) | int'(upd_taken_i)) & (N - 1);
`ifdef GSHARE_SPECULATIVE_HISTORY_EN
                        end else if (ev) begin
                            m_ghr = ((m_ghr << 1) | int'(et)) & (N - 1);
`else
                        end else if (upd_valid_i) begin
                            m_ghr = ((m_ghr << 1) | int'(upd_taken_i)) & (N - 1);
`endif
                        end
                    end
                end
            end
        end
    end

    task automatic mid();
        @(negedge clk_i);
        #1;
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        flush_bp_i       = 1'b0;
        debug_mode_i     = 1'b0;
        lookup_valid_i   = 1'b0;
        lookup_pc_i      = '0;
        upd_valid_i      = 1'b0;
        upd_pc_i         = '0;
        upd_ghr_i        = '0;
        upd_taken_i      = 1'b0;
        upd_mispredict_i = 1'b0;
    endtask

    task automatic drive_upd(input bit v, input logic [63:0] pc, input int ghr, input bit t, input bit m);
        upd_valid_i      = v;
        upd_pc_i         = pc;
        upd_ghr_i        = 9'(ghr);
        upd_taken_i      = t;
        upd_mispredict_i = m;
    endtask

    task automatic lookup(input int idx);
        lookup_valid_i = 1'b1;
        lookup_pc_i    = pc_for(idx);
    endtask

    // Runs one flush sweep with lookups active; returns the number of busy cycles seen.
    task automatic count_busy(input int restart_at, input int drop_at, output int cnt);
        cnt = 0;
        for (int n = 0; n < 1000; n++) begin
            idle();
            lookup_valid_i = 1'b1;
            lookup_pc_i    = {$urandom, $urandom};
            flush_bp_i     = (n == restart_at);
            if (n == drop_at) drive_upd(1'b1, 64'h100, 1, 1'b1, 1'b1);
            mid();
            if (!busy_o) break;
            cnt++;
            check("clear_pred_valid", 64'(pred_valid_o), 64'(0));
            nxt();
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int cnt;
        logic [63:0] exp_ghr;
        bit exp_t [4];
        idle();
        nxt();
        nxt();
        rst_ni = 1'b1;

        // Reset state seen through a lookup.
        lookup_valid_i = 1'b1;
        lookup_pc_i    = 64'h8000_0000;
        mid();
        check("reset_lookup_valid", 64'(pred_valid_o), 64'(1));
        check("reset_lookup_taken", 64'(pred_taken_o), 64'(0));
        check("reset_lookup_ghr", 64'(pred_ghr_o), 64'(0));
        nxt();

        // Saturate entry 128 upward; each lookup sees the pre-update value.
        exp_t = '{0, 1, 1, 1};
        for (int k = 0; k < 4; k++) begin
            idle();
            lookup(128);
            drive_upd(1'b1, 64'h100, 0, 1'b1, 1'b0);
            mid();
            check("sat_up_pre", 64'(pred_taken_o), 64'(exp_t[k]));
            nxt();
        end
        idle();
        lookup(128);
        mid();
        check("sat_up_taken", 64'(pred_taken_o), 64'(1));
`ifdef GSHARE_SPECULATIVE_HISTORY_EN
        exp_ghr = 64'd7;
`else
        exp_ghr = 64'd15;
`endif
        check("ghr_after_train", 64'(pred_ghr_o), exp_ghr);
        nxt();

        // Saturate downward to 00, then prove it held at 00 rather than 01.
        exp_t = '{1, 1, 0, 0};
        for (int k = 0; k < 4; k++) begin
            idle();
            lookup(128);
            drive_upd(1'b1, 64'h100, 0, 1'b0, 1'b0);
            mid();
            check("sat_dn_pre", 64'(pred_taken_o), 64'(exp_t[k]));
            nxt();
        end
        idle();
        lookup(128);
        drive_upd(1'b1, 64'h100, 0, 1'b1, 1'b0);
        mid();
        check("sat_dn_floor", 64'(pred_taken_o), 64'(0));
        nxt();
        idle();
        lookup(128);
        mid();
        check("sat_dn_from_zero", 64'(pred_taken_o), 64'(0));
        nxt();

        // History: zero the GHR with a mispredict, build 0b111, then restore.
        idle();
        drive_upd(1'b1, 64'h0, 0, 1'b0, 1'b1);
        nxt();
        idle();
`ifdef GSHARE_SPECULATIVE_HISTORY_EN
        drive_upd(1'b1, 64'h100, 0, 1'b1, 1'b0);
        mid();
        check("ghr_zeroed", 64'(pred_ghr_o), 64'(0));
        nxt();
        drive_upd(1'b1, 64'h100, 0, 1'b1, 1'b0);
        nxt();
        idle();
        for (int k = 0; k < 3; k++) begin
            lookup(128);
            mid();
            check("spec_pred_taken", 64'(pred_taken_o), 64'(1));
            nxt();
        end
`else
        for (int k = 0; k < 3; k++) begin
            drive_upd(1'b1, 64'h100, 0, 1'b1, 1'b0);
            mid();
            if (k == 0) check("ghr_zeroed", 64'(pred_ghr_o), 64'(0));
            nxt();
        end
`endif
        idle();
        lookup(128);
        drive_upd(1'b1, 64'h200, 5, 1'b0, 1'b1);
        mid();
        check("ghr_built", 64'(pred_ghr_o), 64'd7);
        check("restore_cycle_valid", 64'(pred_valid_o), 64'(1));
        nxt();
        idle();
        mid();
        check("ghr_restored", 64'(pred_ghr_o), 64'd10);
        nxt();

        // Debug mode freezes training and history; lookups still answer.
        idle();
        debug_mode_i = 1'b1;
        lookup(300);
        drive_upd(1'b1, upd_pc_of(300), 0, 1'b1, 1'b1);
        mid();
        check("debug_lookup_valid", 64'(pred_valid_o), 64'(1));
        check("debug_lookup_taken", 64'(pred_taken_o), 64'(0));
        nxt();
        idle();
        lookup(300);
        mid();
        check("debug_ctr_frozen", 64'(pred_taken_o), 64'(0));
        check("debug_ghr_frozen", 64'(pred_ghr_o), 64'd10);
        nxt();

        // Random traffic concentrated on a small set of entries.
        for (int n = 0; n < 1500; n++) begin
            idle();
            lookup_valid_i   = 1'($urandom_range(0, 1));
            lookup_pc_i      = ($urandom_range(0, 1) == 1) ? pc_for($urandom_range(0, 31)) : {$urandom, $urandom};
            upd_valid_i      = 1'($urandom_range(0, 1));
            upd_pc_i         = {$urandom, $urandom};
            upd_pc_i[9:1]    = 9'($urandom_range(0, 31));
            upd_ghr_i        = 9'($urandom_range(0, 3));
            upd_taken_i      = 1'($urandom_range(0, 1));
            upd_mispredict_i = ($urandom_range(0, 3) == 0);
            debug_mode_i     = ($urandom_range(0, 15) == 0);
            nxt();
        end

        // Flush sweep: exactly N busy cycles, lookups blocked, mid-sweep update dropped.
        idle();
        flush_bp_i = 1'b1;
        mid();
        check("flush_cycle_not_busy", 64'(busy_o), 64'(0));
        nxt();
        count_busy(-1, 10, cnt);
        check("busy_cycles", 64'(cnt), 64'(N));
        check("post_clear_ghr", 64'(pred_ghr_o), 64'(0));
        check("post_clear_valid", 64'(pred_valid_o), 64'(1));
        nxt();

        // Every entry must be back at 01: one taken step reads 1, one not-taken step reads 0.
        for (int e = 0; e < N; e++) begin
            idle();
            drive_upd(1'b1, upd_pc_of(e), 0, 1'b1, 1'b0);
            nxt();
            idle();
            lookup(e);
            drive_upd(1'b1, upd_pc_of(e), 0, 1'b0, 1'b0);
            mid();
            check("clear_entry_up", 64'(pred_taken_o), 64'(1));
            nxt();
            idle();
            lookup(e);
            mid();
            check("clear_entry_dn", 64'(pred_taken_o), 64'(0));
            nxt();
        end

        // A flush inside the sweep restarts it: 6 cycles then a full N.
        idle();
        flush_bp_i = 1'b1;
        nxt();
        count_busy(5, -1, cnt);
        check("restart_busy_cycles", 64'(cnt), 64'(N + 6));
        nxt();

        // Drive entry 128 to 00, then reset during a sweep before the sweep reaches it.
        for (int k = 0; k < 2; k++) begin
            idle();
            drive_upd(1'b1, 64'h100, 0, 1'b0, 1'b0);
            nxt();
        end
        idle();
        flush_bp_i = 1'b1;
        nxt();
        idle();
        repeat (100) nxt();
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_async_busy", 64'(busy_o), 64'(0));
        check("rst_async_ghr", 64'(pred_ghr_o), 64'(0));
        mid();
        nxt();
        rst_ni = 1'b1;
        lookup_valid_i = 1'b1;
        lookup_pc_i    = 64'h100;
        mid();
        check("after_rst_valid", 64'(pred_valid_o), 64'(1));
        check("after_rst_busy", 64'(busy_o), 64'(0));
        check("after_rst_ghr", 64'(pred_ghr_o), 64'(0));
        nxt();
        idle();
        drive_upd(1'b1, 64'h100, 0, 1'b1, 1'b0);
        nxt();
        idle();
        lookup(128);
        mid();
        check("rst_ctr", 64'(pred_taken_o), 64'(1));
        nxt();
        idle();
        nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
